// File: rtl/pulse_arbiter_pkg.sv
// Shared types and constants for the pulse arbiter: FSM state enum, default
// sizing, counter widths and a saturating-increment helper.
package pulse_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GUARD = 2'd2
    } state_e;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_GUARD_CYCLES = 20;
    localparam int DROP_CNT_W       = 8;
    localparam int GUARD_CNT_W      = 8;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        logic [DROP_CNT_W-1:0] res;
        if (v == {DROP_CNT_W{1'b1}}) begin
            res = v;
        end else begin
            res = v + DROP_CNT_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/pulse_arbiter_rr_select.sv
// Combinational round-robin selector: first set request at or after
// (last_grant + 1) mod NUM_REQ, with a valid flag when any request is set.
module rr_select
    import pulse_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_valid
);

    logic [IDX_W-1:0] w_idx;

    // Scan requesters in rotating priority order, keep the first hit.
    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDX_W'((int'(i_last_grant) + k) % NUM_REQ);
            if (!o_valid && i_req[w_idx]) begin
                o_valid  = 1'b1;
                o_winner = w_idx;
            end else begin
                o_valid  = o_valid;
            end
        end
    end

endmodule

// File: rtl/pulse_arbiter.sv
// Round-robin arbiter issuing guarded single-cycle pulses onto a shared channel.
// Optional macro PULSE_ARBITER_DROP_CNT_EN adds a saturating drop counter output.
module pulse_arbiter
    import pulse_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_pulse,
    output logic                       pulse_out,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [NUM_REQ-1:0]         pending,
    output logic                       busy,
`ifdef PULSE_ARBITER_DROP_CNT_EN
    output logic [DROP_CNT_W-1:0]      drop_cnt,
`endif
    output logic                       drop_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_e                 r_state;
    state_e                 w_next_state;
    logic                   r_pulse_out;
    logic [IDX_W-1:0]       r_grant_id;
    logic [IDX_W-1:0]       r_last_grant;
    logic [NUM_REQ-1:0]     r_pending;
    logic                   r_busy;
    logic                   r_drop_err;
    logic [GUARD_CNT_W-1:0] r_guard_cnt;
    logic [GUARD_CNT_W-1:0] w_guard_nxt;
    logic [NUM_REQ-1:0]     w_clr_mask;
    logic [NUM_REQ-1:0]     w_pending_nxt;
    logic                   w_drop;
    logic                   w_issue;
    logic [IDX_W-1:0]       w_winner;
    logic                   w_valid;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_select (
        .i_req        (r_pending),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner),
        .o_valid      (w_valid)
    );

    // A new request beats the clear of the same bit; only a still-held bit drops.
    always_comb begin
        w_clr_mask = '0;
        if (r_state == ISSUE) begin
            w_clr_mask[r_grant_id] = 1'b1;
        end else begin
            w_clr_mask = '0;
        end
        w_pending_nxt = (r_pending & ~w_clr_mask) | req_pulse;
        w_drop        = |(req_pulse & r_pending & ~w_clr_mask);
    end

    always_comb begin
        w_next_state = r_state;
        w_guard_nxt  = r_guard_cnt;
        w_issue      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_next_state = ISSUE;
                    w_issue      = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            ISSUE: begin
                w_next_state = GUARD;
                w_guard_nxt  = GUARD_CNT_W'(GUARD_CYCLES - 1);
            end
            GUARD: begin
                if (r_guard_cnt == '0) begin
                    w_next_state = IDLE;
                    w_guard_nxt  = '0;
                end else begin
                    w_guard_nxt  = r_guard_cnt - GUARD_CNT_W'(1);
                end
            end
            default: begin
                w_next_state = IDLE;
                w_guard_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pulse_out  <= 1'b0;
            r_grant_id   <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_pending    <= '0;
            r_busy       <= 1'b0;
            r_drop_err   <= 1'b0;
            r_guard_cnt  <= '0;
        end else begin
            r_state     <= w_next_state;
            r_pulse_out <= w_issue;
            if (w_issue) begin
                r_grant_id   <= w_winner;
                r_last_grant <= w_winner;
            end else begin
                r_grant_id   <= r_grant_id;
                r_last_grant <= r_last_grant;
            end
            r_pending   <= w_pending_nxt;
            r_busy      <= (w_next_state != IDLE);
            r_drop_err  <= w_drop;
            r_guard_cnt <= w_guard_nxt;
        end
    end

`ifdef PULSE_ARBITER_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (r_drop_err) begin
            r_drop_cnt <= sat_inc(r_drop_cnt);
        end else begin
            r_drop_cnt <= r_drop_cnt;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign pulse_out = r_pulse_out;
    assign grant_id  = r_grant_id;
    assign pending   = r_pending;
    assign busy      = r_busy;
    assign drop_err  = r_drop_err;

endmodule

// File: tb/tb_pulse_arbiter.sv
// Self-checking bench for pulse_arbiter: directed scenarios plus randomized
// traffic compared against a cycle-indexed behavioural model.
module tb_pulse_arbiter;

    localparam int N = 4;
    localparam int G = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_pulse = 4'b0000;
    logic       pulse_out;
    logic [1:0] grant_id;
    logic [3:0] pending;
    logic       busy;
    logic       drop_err;
`ifdef PULSE_ARBITER_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int checks = 0;
    int fails  = 0;

    // Model: pulse times are tracked as cycle numbers, not as FSM states.
    int       m_now   = 0;
    int       m_issue = -1000;
    int       m_grant = 0;
    int       m_last  = N - 1;
    int       m_drops = 0;
    bit [3:0] m_pend  = 4'b0000;
    bit       m_drop  = 1'b0;

    pulse_arbiter #(
        .NUM_REQ      (N),
        .GUARD_CYCLES (G)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_pulse (req_pulse),
        .pulse_out (pulse_out),
        .grant_id  (grant_id),
        .pending   (pending),
        .busy      (busy),
`ifdef PULSE_ARBITER_DROP_CNT_EN
        .drop_cnt  (drop_cnt),
`endif
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    task automatic tick(input logic [3:0] req, input logic rst_v);
        bit [3:0] clr;
        bit       found;
        int       idx;
        req_pulse = req;
        rst       = rst_v;
        @(posedge clk);
        if (rst_v) begin
            m_pend  = 4'b0000;
            m_issue = -1000;
            m_grant = 0;
            m_last  = N - 1;
            m_drop  = 1'b0;
            m_drops = 0;
        end else begin
            clr    = (m_issue == m_now) ? (4'b0001 << m_grant) : 4'b0000;
            m_drop = |(req & m_pend & ~clr);
            if (m_drop) m_drops++;
            if ((m_now > m_issue + G) && (m_pend != 4'b0000)) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    idx = (m_last + k) % N;
                    if (!found && m_pend[idx]) begin
                        found   = 1'b1;
                        m_grant = idx;
                        m_last  = idx;
                        m_issue = m_now + 1;
                    end
                end
            end
            m_pend = (m_pend & ~clr) | req;
        end
        m_now++;
        #1;
    endtask

    task automatic test_reset();
        tick(4'b1111, 1'b1);
        tick(4'b1111, 1'b1);
        checks++; if (pulse_out !== 1'b0) begin fails++; $display("FAIL reset pulse_out got %b want 0", pulse_out); end
        checks++; if (grant_id !== 2'd0) begin fails++; $display("FAIL reset grant_id got %0d want 0", grant_id); end
        checks++; if (pending !== 4'b0000) begin fails++; $display("FAIL reset pending got %b want 0000", pending); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy got %b want 0", busy); end
        checks++; if (drop_err !== 1'b0) begin fails++; $display("FAIL reset drop_err got %b want 0", drop_err); end
    endtask

    task automatic test_single();
        int t;
        int busy_cnt;
        bit exp_pulse;
        bit exp_busy;
        tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b0);
        tick(4'b0000, 1'b0);
        t = m_now;
        tick(4'b0010, 1'b0);
        busy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            exp_pulse = (m_now == t + 2);
            exp_busy  = (m_now >= t + 2) && (m_now <= t + 22);
            checks++; if (pulse_out !== exp_pulse) begin fails++; $display("FAIL single pulse_out cyc+%0d got %b want %b", m_now - t, pulse_out, exp_pulse); end
            checks++; if (busy !== exp_busy) begin fails++; $display("FAIL single busy cyc+%0d got %b want %b", m_now - t, busy, exp_busy); end
            if (exp_pulse) begin
                checks++; if (grant_id !== 2'd1) begin fails++; $display("FAIL single grant_id got %0d want 1", grant_id); end
            end
            if (busy === 1'b1) busy_cnt++;
            tick(4'b0000, 1'b0);
        end
        checks++; if (busy_cnt != 21) begin fails++; $display("FAIL single busy_len got %0d want 21", busy_cnt); end
        checks++; if (grant_id !== 2'd1) begin fails++; $display("FAIL single grant_hold got %0d want 1", grant_id); end
    endtask

    task automatic test_all_simultaneous();
        int t;
        int cyc_q[$];
        int gid_q[$];
        tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b1);
        t = m_now;
        tick(4'b1111, 1'b0);
        for (int i = 0; i < 90; i++) begin
            if (pulse_out === 1'b1) begin
                cyc_q.push_back(m_now);
                gid_q.push_back(int'(grant_id));
            end
            tick(4'b0000, 1'b0);
        end
        checks++; if (cyc_q.size() != 4) begin fails++; $display("FAIL all_sim pulse_count got %0d want 4", cyc_q.size()); end
        for (int k = 0; k < 4; k++) begin
            if (k < cyc_q.size()) begin
                checks++; if (cyc_q[k] != t + 2 + 22 * k) begin fails++; $display("FAIL all_sim pulse%0d_cycle got +%0d want +%0d", k, cyc_q[k] - t, 2 + 22 * k); end
                checks++; if (gid_q[k] != k) begin fails++; $display("FAIL all_sim pulse%0d_grant got %0d want %0d", k, gid_q[k], k); end
            end
        end
    endtask

    task automatic test_drop();
        int s;
        int p2_cnt;
        int p2_cyc;
        bit exp_drop;
        tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b1);
        s = m_now;
        tick(4'b0001, 1'b0);
        for (int i = 0; i < 4; i++) tick(4'b0000, 1'b0);
        tick(4'b0100, 1'b0);
        tick(4'b0100, 1'b0);
        p2_cnt = 0;
        p2_cyc = -1;
        for (int i = 0; i < 60; i++) begin
            exp_drop = (m_now == s + 7);
            checks++; if (drop_err !== exp_drop) begin fails++; $display("FAIL drop drop_err cyc+%0d got %b want %b", m_now - s, drop_err, exp_drop); end
            if (pulse_out === 1'b1 && grant_id === 2'd2) begin
                p2_cnt++;
                p2_cyc = m_now;
            end
            tick(4'b0000, 1'b0);
        end
        checks++; if (p2_cnt != 1) begin fails++; $display("FAIL drop req2_pulses got %0d want 1", p2_cnt); end
        checks++; if (p2_cyc != s + 24) begin fails++; $display("FAIL drop req2_cycle got +%0d want +24", p2_cyc - s); end
    endtask

    task automatic test_set_wins();
        int s;
        int pulses;
        int p_cyc;
        tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b1);
        s = m_now;
        tick(4'b0001, 1'b0);
        tick(4'b0000, 1'b0);
        checks++; if (pulse_out !== 1'b1) begin fails++; $display("FAIL set_wins issue_pulse got %b want 1", pulse_out); end
        tick(4'b0001, 1'b0);
        checks++; if (pending[0] !== 1'b1) begin fails++; $display("FAIL set_wins pending0 got %b want 1", pending[0]); end
        checks++; if (drop_err !== 1'b0) begin fails++; $display("FAIL set_wins drop_err got %b want 0", drop_err); end
        pulses = 0;
        p_cyc  = -1;
        for (int i = 0; i < 40; i++) begin
            if (pulse_out === 1'b1) begin
                pulses++;
                p_cyc = m_now;
                checks++; if (grant_id !== 2'd0) begin fails++; $display("FAIL set_wins grant got %0d want 0", grant_id); end
            end
            tick(4'b0000, 1'b0);
        end
        checks++; if (pulses != 1) begin fails++; $display("FAIL set_wins second_pulses got %0d want 1", pulses); end
        checks++; if (p_cyc != s + 24) begin fails++; $display("FAIL set_wins second_cycle got +%0d want +24", p_cyc - s); end
    endtask

    task automatic test_reset_mid_guard();
        tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b1);
        tick(4'b0001, 1'b0);
        for (int i = 0; i < 3; i++) tick(4'b0000, 1'b0);
        tick(4'b0101, 1'b0);
        for (int i = 0; i < 7; i++) tick(4'b0000, 1'b0);
        checks++; if (pending !== 4'b0101) begin fails++; $display("FAIL rst_guard pending_before got %b want 0101", pending); end
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_guard busy_before got %b want 1", busy); end
        tick(4'b0000, 1'b1);
        checks++; if ({pulse_out, grant_id, pending, busy, drop_err} !== 9'd0) begin
            fails++; $display("FAIL rst_guard outputs got %b want 000000000", {pulse_out, grant_id, pending, busy, drop_err});
        end
        for (int i = 0; i < 50; i++) begin
            tick(4'b0000, 1'b0);
            checks++; if (pulse_out !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rst_guard after pulse/busy got %b%b want 00", pulse_out, busy); end
        end
    endtask

    task automatic test_random();
        logic [3:0] req;
        logic       r;
        bit         exp_pulse;
        bit         exp_busy;
        tick(4'b0000, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) req[b] = ($urandom_range(0, 23) == 0);
            r = ($urandom_range(0, 399) == 0);
            tick(req, r);
            exp_pulse = (m_issue == m_now);
            exp_busy  = (m_now >= m_issue) && (m_now <= m_issue + G);
            checks++; if (pulse_out !== exp_pulse) begin fails++; $display("FAIL random pulse_out cyc %0d got %b want %b", m_now, pulse_out, exp_pulse); end
            checks++; if (busy !== exp_busy) begin fails++; $display("FAIL random busy cyc %0d got %b want %b", m_now, busy, exp_busy); end
            checks++; if (grant_id !== 2'(m_grant)) begin fails++; $display("FAIL random grant_id cyc %0d got %0d want %0d", m_now, grant_id, m_grant); end
            checks++; if (pending !== m_pend) begin fails++; $display("FAIL random pending cyc %0d got %b want %b", m_now, pending, m_pend); end
            checks++; if (drop_err !== m_drop) begin fails++; $display("FAIL random drop_err cyc %0d got %b want %b", m_now, drop_err, m_drop); end
        end
    endtask

`ifdef PULSE_ARBITER_DROP_CNT_EN
    task automatic test_drop_cnt();
        int exp_cnt;
        tick(4'b0000, 1'b1);
        for (int i = 0; i < 400; i++) tick(4'b1111, 1'b0);
        for (int i = 0; i < 3; i++) tick(4'b0000, 1'b0);
        exp_cnt = (m_drops > 255) ? 255 : m_drops;
        checks++; if (int'(drop_cnt) != exp_cnt) begin fails++; $display("FAIL drop_cnt saturate got %0d want %0d", drop_cnt, exp_cnt); end
        tick(4'b0000, 1'b1);
        checks++; if (drop_cnt !== 8'd0) begin fails++; $display("FAIL drop_cnt reset got %0d want 0", drop_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_all_simultaneous();
        test_drop();
        test_set_wins();
        test_reset_mid_guard();
        test_random();
`ifdef PULSE_ARBITER_DROP_CNT_EN
        test_drop_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pulse_arbiter.md
PULSE_ARBITER -- requirements
Module: pulse_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL be the number of pulse requesters, legal range 2..16.
REQ-002 Parameter GUARD_CYCLES, default 20, SHALL be the number of clk cycles held idle after each issued pulse, legal range 1..255. 20 covers two slow-domain periods at the 10:1 clk_fast:clk_slow ratio.
REQ-003 clk  input  1  SHALL be the single clock; the fast domain driving the pulse-transfer channel.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 req_pulse  input  NUM_REQ  SHALL carry one single-cycle pulse request per requester.
REQ-006 pulse_out  output  1  SHALL be a single-cycle pulse to the shared channel's data_in.
REQ-007 grant_id  output  $clog2(NUM_REQ)  SHALL be the index of the requester served by the current or most recent pulse_out.
REQ-008 pending  output  NUM_REQ  SHALL be the per-requester latched-request vector.
REQ-009 busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-010 drop_err  output  1  SHALL be a single-cycle flag for a discarded request.

Function
REQ-011 The FSM SHALL have three states, IDLE, ISSUE and GUARD, with all outputs registered.
REQ-012 On a clk edge with req_pulse[i]=1, pending[i] SHALL be set.
REQ-013 If pending[i] is already 1 and is not being cleared that cycle, the request SHALL be discarded and drop_err SHALL be 1 for the next cycle.
REQ-014 In IDLE with pending!=0, the block SHALL select a winner by round-robin, starting at index (last_grant+1) mod NUM_REQ, and move to ISSUE.
REQ-015 In IDLE with pending==0, the block SHALL stay in IDLE.
REQ-016 In ISSUE, pulse_out SHALL be 1 for exactly one cycle, grant_id SHALL equal the winner, and pending[winner] SHALL clear at the end of the cycle.
REQ-017 ISSUE SHALL always move to GUARD, loading guard_cnt=GUARD_CYCLES-1.
REQ-018 In GUARD, guard_cnt SHALL decrement each cycle; at 0 the FSM SHALL move to IDLE.
REQ-019 Latency: a req_pulse in cycle t on an idle block with no pending requests SHALL give pulse_out=1 in cycle t+2.
REQ-020 The minimum spacing between pulse_out rising edges SHALL be GUARD_CYCLES+2 cycles.
REQ-021 If req_pulse[winner] arrives in the same cycle pending[winner] clears, the set SHALL win: pending stays 1 and drop_err stays 0.
REQ-022 Requests arriving during ISSUE or GUARD SHALL be latched in pending and served later, never dropped unless already pending.
REQ-023 After reset, last_grant SHALL equal NUM_REQ-1, so requester 0 has first priority.

Reset
REQ-024 With rst=1 at a clk edge: state=IDLE, pulse_out=0, grant_id=0, pending=0, busy=0, drop_err=0, guard_cnt=0, last_grant=NUM_REQ-1.
REQ-025 Reset asserted mid-ISSUE or mid-GUARD SHALL abort the operation, and all pending requests SHALL be lost.
REQ-026 req_pulse sampled while rst=1 SHALL be ignored.

Configuration
REQ-027 Macro PULSE_ARBITER_DROP_CNT_EN, when defined, SHALL add output drop_cnt (8 bits), which increments on every drop_err, saturates at 255, and resets to 0.
REQ-028 Without PULSE_ARBITER_DROP_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 A package pulse_arbiter_pkg SHALL hold the state enum (IDLE/ISSUE/GUARD), default NUM_REQ and GUARD_CYCLES constants, and the drop counter width.
REQ-030 The round-robin selector SHALL be a separate combinational sub-module rr_select (inputs: request vector, last grant; output: winner index and valid).

Verification
REQ-031 Single request: rst for 2 cycles, then req_pulse=4'b0010 in cycle 5 -> pulse_out=1 in cycle 7 only, grant_id=1, busy high for cycles 7..27.
REQ-032 All requesters simultaneous: req_pulse=4'b1111 in one cycle -> four pulse_outs with grant_ids 0,1,2,3, spaced exactly 22 cycles apart.
REQ-033 Drop: req_pulse[2] in cycle 10 and again in cycle 11 during GUARD of another grant -> drop_err=1 in cycle 12 only, and one pulse for requester 2.
REQ-034 Set-wins collision: req_pulse[0] coincides with the ISSUE cycle for requester 0 -> pending[0] stays 1, drop_err=0, and a second pulse is issued 22 cycles later.
REQ-035 Reset mid-GUARD: pending=4'b0101 with rst=1 at guard_cnt=10 -> next cycle all outputs are 0 and no pulse_out follows.
REQ-036 With PULSE_ARBITER_DROP_CNT_EN defined: 300 forced drops -> drop_cnt=255.
